mod_mul_unit: RTL and testbench
===============================

Name: mod_mul_unit

Overview:
- Responder for the start/done call handshake used by the sequential arithmetic controllers, such as the fast modular-exponentiation engine.
- On a one-cycle start pulse, latches a, b, m and computes (a*b) mod m bit-serially: a WIDTH-cycle restoring reduction of a, then WIDTH interleaved shift-add-reduce steps.
- Asserts done with a stable result when finished. Any caller in the design can instantiate it in place of its multiply-mod sub-call.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, any value (may be ≥ m)
b  input  WIDTH  multiplier, any value
m  input  WIDTH  modulus; 0 is a defined special case
result  output  WIDTH  (a*b) mod m; valid while done=1
done  output  1  1 = idle with result valid; 0 = busy

Behaviour:
- Reset: reset=0 immediately forces state=IDLE, result=0, done=0, and all internal registers (ra, rb, rm, acc, cnt) to 0, regardless of the clock. Reset asserted mid-operation aborts the computation with no further output.
- States: IDLE, REDUCE, MUL, FINISH.
- IDLE:
  - start=0: done<=1, stay IDLE, result held.
  - start=1: ra<=a, rb<=b, rm<=m, acc<=0, cnt<=WIDTH-1, done<=0. If m==0, next state is FINISH with acc forced to 0; otherwise next state is REDUCE.
  - The caller's rule is: pulse start for one cycle, then poll done. done is therefore 0 on the edge after the start-sampling edge.
- REDUCE (WIDTH cycles, cnt WIDTH-1..0):
  - t = {acc,1'b0} | ra[cnt], computed in WIDTH+1 bits.
  - acc <= (t ≥ rm) ? t-rm : t.
  - At cnt=0: ra <= the new acc, acc <= 0, cnt <= WIDTH-1, go to MUL.
  - Invariant: acc < rm.
- MUL (WIDTH cycles, cnt WIDTH-1..0, scanning rb MSB first):
  - d = 2*acc, reduced by one conditional subtract of rm.
  - s = d + (rb[cnt] ? ra : 0), reduced by one conditional subtract of rm.
  - acc <= s.
  - All intermediates are WIDTH+1 bits wide; there is no overflow because acc < rm and ra < rm.
  - At cnt=0, go to FINISH.
- FINISH: result<=acc, done<=1, go to IDLE.
- Latency, counted from the start-sampling edge E:
  - m≠0: done=1 and result valid after edge E+2*WIDTH+1, i.e. 65 cycles for WIDTH=32.
  - m==0: done=1 with result=0 after edge E+1.
- result changes only in FINISH and at reset; it is stable throughout busy periods and while idle.
- start while busy (REDUCE/MUL/FINISH) is ignored: no restart, no queuing.
- a, b, m may change freely after the start-sampling edge; only the latched copies are used.
- m==1 takes the normal path and yields result=0.
- Back-to-back requests: start may be high on the first IDLE cycle after FINISH and is accepted there.
- First clock after reset release with start=0: done<=1. With start=1 on that clock, the request is accepted directly.

Test Plan:
- a=7, b=5, m=11, one-cycle start -> done=0 on the next edge, done=1 with result=2 exactly 65 cycles after the start edge; result stable until the next FINISH.
- a=100, b=3, m=7 (a ≥ m) -> result=6. Then a=0xFFFFFFFF, b=0xFFFFFFFF, m=0xFFFFFFFB -> result=16. Both use back-to-back requests, each 65-cycle latency.
- m=0, a=9, b=9 -> result=0, done=1 one cycle after the start edge. Then m=1, a=9, b=9 -> result=0 after 65 cycles.
- Assert start again at cycles 10 and 40 of a busy run, and change a/b/m mid-run -> original result unaffected, no extra completion, done stays 0 until cycle 65.
- Drive reset=0 between clock edges at cycle 30 of a run -> result=0 and done=0 immediately, with no clock edge needed. After release: done=1 on the first edge with start=0, and a new request (a=2, b=3, m=5) gives result=1.
- Integration: two instances under the fast modular-exponentiation controller computing 3^13 mod 1000 -> final result=323; every request/response follows the pulse-start, poll-done protocol.

Source files
------------

// File: rtl/mod_mul_unit_if.sv
// Start/done call handshake between a sequential arithmetic controller
// and a multiply-mod responder.
interface mod_mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (output start, output a, output b, output m,
                  input  result, input done);
  modport slave  (input  start, input  a, input  b, input  m,
                  output result, output done);
endinterface

// File: rtl/mod_mul_unit.sv
// Bit-serial (a*b) mod m responder: WIDTH-cycle restoring reduction of a,
// then WIDTH MSB-first shift-add-reduce steps over b.
module mod_mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mod_mul_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_MUL,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] rm_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  logic [WIDTH:0] rm_x;
  logic [WIDTH:0] red_t;
  logic [WIDTH:0] red_d;
  logic [WIDTH:0] dbl_t;
  logic [WIDTH:0] dbl_r;
  logic [WIDTH:0] sum_t;
  logic [WIDTH:0] sum_d;

  // One extra bit of headroom suffices since acc and ra stay below rm.
  always_comb begin
    rm_x  = {1'b0, rm_q};
    red_t = {acc_q, ra_q[cnt_q]};
    red_d = (red_t >= rm_x) ? (red_t - rm_x) : red_t;
    dbl_t = {acc_q, 1'b0};
    dbl_r = (dbl_t >= rm_x) ? (dbl_t - rm_x) : dbl_t;
    sum_t = dbl_r + (rb_q[cnt_q] ? {1'b0, ra_q} : {(WIDTH + 1){1'b0}});
    sum_d = (sum_t >= rm_x) ? (sum_t - rm_x) : sum_t;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rm_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            ra_q    <= bus.a;
            rb_q    <= bus.b;
            rm_q    <= bus.m;
            acc_q   <= '0;
            cnt_q   <= CNT_TOP;
            done_q  <= 1'b0;
            // A zero modulus short-circuits to a zero result.
            state_q <= (bus.m == '0) ? S_FINISH : S_REDUCE;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_REDUCE: begin
          if (cnt_q == '0) begin
            ra_q    <= red_d[WIDTH-1:0];
            acc_q   <= '0;
            cnt_q   <= CNT_TOP;
            state_q <= S_MUL;
          end else begin
            acc_q <= red_d[WIDTH-1:0];
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_MUL: begin
          acc_q <= sum_d[WIDTH-1:0];
          if (cnt_q == '0) begin
            state_q <= S_FINISH;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FINISH: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_mod_mul_unit.sv
// Self-checking bench for mod_mul_unit against a plain-arithmetic (a*b)%m model.
module tb_mod_mul_unit;
  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = 2 * WIDTH + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mod_mul_unit_if #(.WIDTH(WIDTH)) bus ();
  mod_mul_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_mulmod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] m);
    longint unsigned p;
    if (m == '0) return '0;
    p = 64'(a) * 64'(b);
    return WIDTH'(p % 64'(m));
  endfunction

  // Issues one request from a post-edge point and polls done with a bounded wait.
  task automatic run_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] m, input bit poke,
                         output logic [WIDTH-1:0] res, output int lat,
                         output logic busy0, output bit stable);
    logic [WIDTH-1:0] held;
    held      = bus.result;
    bus.a     = a;
    bus.b     = b;
    bus.m     = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy0  = bus.done;
    stable = (bus.result === held);
    lat    = -1;
    for (int n = 1; n <= LAT + 10; n++) begin
      if (poke && (n == 10 || n == 40)) begin
        bus.start = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.m = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.result !== held) stable = 1'b0;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.m = '0;
    #3;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++;
    if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL reset_release_done got %b want 1", bus.done); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res; int lat; logic busy0; bit stable;
    run_req(7, 5, 11, 1'b0, res, lat, busy0, stable);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy0); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (res !== 32'd2) begin errors++; $display("FAIL basic_result got %0d want 2", res); end
    checks++;
    if (!stable) begin errors++; $display("FAIL basic_stable got 0 want 1"); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] va [3] = '{32'd100, 32'hFFFF_FFFF, 32'd12345};
    logic [WIDTH-1:0] vb [3] = '{32'd3, 32'hFFFF_FFFF, 32'd67890};
    logic [WIDTH-1:0] vm [3] = '{32'd7, 32'hFFFF_FFFB, 32'd1};
    logic [WIDTH-1:0] vr [3] = '{32'd6, 32'd16, 32'd0};
    logic [WIDTH-1:0] res; int lat; logic busy0; bit stable;
    for (int i = 0; i < 3; i++) begin
      run_req(va[i], vb[i], vm[i], 1'b0, res, lat, busy0, stable);
      checks++;
      if (res !== vr[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, res, vr[i]); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, LAT); end
      checks++;
      if (busy0 !== 1'b0 || !stable) begin errors++; $display("FAIL b2b_busy[%0d] got busy=%b stable=%0d want 0/1", i, busy0, stable); end
    end
  endtask

  task automatic test_mod_zero();
    logic [WIDTH-1:0] res; int lat; logic busy0; bit stable;
    run_req(7, 5, 11, 1'b0, res, lat, busy0, stable);
    run_req(9, 9, 0, 1'b0, res, lat, busy0, stable);
    checks++;
    if (res !== '0) begin errors++; $display("FAIL modzero_result got %h want 0", res); end
    checks++;
    if (lat != 1 || busy0 !== 1'b0) begin errors++; $display("FAIL modzero_latency got %0d busy=%b want 1 busy=0", lat, busy0); end
    run_req(7, 5, 11, 1'b0, res, lat, busy0, stable);
    run_req(9, 9, 1, 1'b0, res, lat, busy0, stable);
    checks++;
    if (res !== '0) begin errors++; $display("FAIL modone_result got %h want 0", res); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL modone_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_busy_start();
    logic [WIDTH-1:0] res; int lat; logic busy0; bit stable;
    logic [WIDTH-1:0] exp_r;
    exp_r = ref_mulmod(32'd123456789, 32'd987654321, 32'd1000003);
    run_req(32'd123456789, 32'd987654321, 32'd1000003, 1'b1, res, lat, busy0, stable);
    checks++;
    if (res !== exp_r) begin errors++; $display("FAIL busy_result got %h want %h", res, exp_r); end
    checks++;
    if (lat != LAT || !stable) begin errors++; $display("FAIL busy_latency got %0d stable=%0d want %0d", lat, stable, LAT); end
    repeat (70) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b1 || bus.result !== exp_r) begin
        errors++; $display("FAIL busy_extra got done=%b res=%h want 1 %h", bus.done, bus.result, exp_r);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] res; int lat; logic busy0; bit stable;
    bus.a = 32'd999; bus.b = 32'd777; bus.m = 32'd1009; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== '0) begin
      errors++; $display("FAIL async_reset got done=%b res=%h want 0 0", bus.done, bus.result);
    end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.result !== '0) begin
      errors++; $display("FAIL async_release got done=%b res=%h want 1 0", bus.done, bus.result);
    end
    run_req(2, 3, 5, 1'b0, res, lat, busy0, stable);
    checks++;
    if (res !== 32'd1 || lat != LAT) begin errors++; $display("FAIL async_after got %0d lat %0d want 1 lat %0d", res, lat, LAT); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, m, res, exp_r; int lat; logic busy0; bit stable;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      m = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom);
      exp_r = ref_mulmod(a, b, m);
      run_req(a, b, m, 1'b0, res, lat, busy0, stable);
      checks++;
      if (res !== exp_r) begin errors++; $display("FAIL rand_result[%0d] a=%h b=%h m=%h got %h want %h", i, a, b, m, res, exp_r); end
      checks++;
      if (lat != ((m == '0) ? 1 : LAT) || busy0 !== 1'b0 || !stable) begin
        errors++; $display("FAIL rand_timing[%0d] got lat=%0d busy=%b stable=%0d", i, lat, busy0, stable);
      end
    end
  endtask

  // Left-to-right square-and-multiply using the unit as its multiply-mod sub-call.
  task automatic test_modexp();
    logic [WIDTH-1:0] r, res; int lat; logic busy0; bit stable;
    logic [3:0] e;
    e = 4'd13;
    r = 1;
    for (int i = 3; i >= 0; i--) begin
      run_req(r, r, 1000, 1'b0, res, lat, busy0, stable);
      checks++;
      if (res !== ref_mulmod(r, r, 1000) || lat != LAT) begin errors++; $display("FAIL modexp_sq[%0d] got %0d lat %0d", i, res, lat); end
      r = res;
      if (e[i]) begin
        run_req(r, 3, 1000, 1'b0, res, lat, busy0, stable);
        checks++;
        if (res !== ref_mulmod(r, 3, 1000) || lat != LAT) begin errors++; $display("FAIL modexp_mul[%0d] got %0d lat %0d", i, res, lat); end
        r = res;
      end
    end
    checks++;
    if (r !== 32'd323) begin errors++; $display("FAIL modexp_final got %0d want 323", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mod_zero();
    test_busy_start();
    test_async_reset();
    test_random();
    test_modexp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
